// File: rtl/sim_report_pkg.sv
// sim_report_pkg: shared write-port address codes, FSM states and watchdog code.
package sim_report_pkg;
  localparam logic [1:0] ADDR_PUSH = 2'd0;
  localparam logic [1:0] ADDR_FINISH = 2'd1;
  localparam logic [1:0] ADDR_KICK = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;
  localparam logic [31:0] WDT_CODE = 32'hDEAD_0000;
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
endpackage

// File: rtl/sim_report_if.sv
// sim_report_if: firmware write port (valid/ready handshake with address and payload).
interface sim_report_if;
  logic valid;
  logic ready;
  logic [1:0] addr;
  logic [31:0] data;
  modport master(output valid, addr, data, input ready);
  modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/sim_report_fifo.sv
// sim_report_fifo: synchronous FIFO with registered read data, loaded on pop.
module sim_report_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_en, rd_en;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) begin
        rp <= rp + 1'b1;
        dout <= mem[rp];
      end
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/sim_report_driver.sv
// sim_report_driver: buffers firmware report words, paces them onto sim_report and signals the verdict.
module sim_report_driver
  import sim_report_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int WDT_CYCLES = 2_000_000
) (
  input  logic        refclk,
  input  logic        rst,
  sim_report_if.slave wr,
  output logic [31:0] sim_report,
  output logic        sim_done,
  output logic        sim_success,
  output logic        wdt_fired
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int WW = $clog2(WDT_CYCLES);
  state_t state, state_n;
  logic [HW-1:0] hold_cnt;
  logic [WW-1:0] wdt_cnt;
  logic [AW:0] count;
  logic [31:0] head;
  logic finish_pend, fin_ok, show, acc, push, pop, expire, full, empty;
  assign acc = wr.valid && wr.ready;
  assign wr.ready = !full || state == DONE;
  assign push = acc && wr.addr == ADDR_PUSH && state != DONE;
  assign expire = state != DONE && wdt_cnt == WW'(WDT_CYCLES - 1) && !acc;
  sim_report_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) fifo (
    .clk(refclk), .rst(rst), .push(push), .din(wr.data), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge refclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    pop = state == IDLE && !empty && !expire;
    state_n = expire ? DONE :
              state == IDLE ? (!empty ? HOLD : finish_pend ? DONE : IDLE) :
              state == HOLD ? (hold_cnt == '0 ? IDLE : HOLD) : DONE;
  end
  // The popped word surfaces one cycle after the pop, once the FIFO read register has it.
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      sim_report <= '0;
      sim_done <= 1'b0;
      sim_success <= 1'b0;
      wdt_fired <= 1'b0;
      finish_pend <= 1'b0;
      fin_ok <= 1'b0;
      show <= 1'b0;
      hold_cnt <= '0;
      wdt_cnt <= '0;
    end else begin
      if (acc && wr.addr == ADDR_FINISH && !finish_pend) begin
        finish_pend <= 1'b1;
        fin_ok <= wr.data[0];
      end
      wdt_cnt <= acc ? '0 : state != DONE ? wdt_cnt + 1'b1 : wdt_cnt;
      show <= pop;
      hold_cnt <= pop ? HW'(HOLD_CYCLES - 1) : (state == HOLD && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
      if (expire) begin
        sim_report <= WDT_CODE | 32'(count);
        sim_done <= 1'b1;
        sim_success <= 1'b0;
        wdt_fired <= 1'b1;
      end else if (state == IDLE && state_n == DONE) begin
        sim_done <= 1'b1;
        sim_success <= fin_ok;
      end else if (show) begin
        sim_report <= head;
      end
    end
endmodule

// File: tb/tb_sim_report_driver.sv
// tb_sim_report_driver: directed and random write sequences checked cycle by cycle
// against a schedule-based model (show time = max(accept+2, previous show+5)).
module tb_sim_report_driver;
  import sim_report_pkg::*;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] sim_report;
  logic sim_done, sim_success, wdt_fired;
  sim_report_if bus();
  sim_report_driver #(.FIFO_DEPTH(8), .HOLD_CYCLES(4), .WDT_CYCLES(100)) dut (
    .refclk(refclk), .rst(rst), .wr(bus), .sim_report(sim_report),
    .sim_done(sim_done), .sim_success(sim_success), .wdt_fired(wdt_fired)
  );
  always #5 refclk = ~refclk;
  int passed = 0;
  int fails = 0;
  int total = 0;
  int e;
  logic [31:0] q_w[$];
  int q_s[$];
  logic [31:0] m_report;
  logic m_done, m_succ, m_fired, m_ready, m_fin, m_fin_ok, tick_acc;
  int m_last_acc, m_last_sched, m_last_show;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    q_w.delete();
    q_s.delete();
    m_report = '0;
    m_done = 1'b0;
    m_succ = 1'b0;
    m_fired = 1'b0;
    m_ready = 1'b1;
    m_fin = 1'b0;
    m_fin_ok = 1'b0;
    e = 0;
    m_last_acc = 0;
    m_last_sched = -100;
    m_last_show = -100;
  endtask
  function automatic int pending(input int after);
    int n = 0;
    foreach (q_s[i]) if (q_s[i] - 1 > after) n++;
    return n;
  endfunction
  task automatic model_edge(input logic acc, input logic [1:0] a, input logic [31:0] d);
    int s;
    if (!m_done) begin
      if (e - m_last_acc == 100 && !acc) begin
        m_report = WDT_CODE | 32'(pending(e - 1));
        m_done = 1'b1;
        m_succ = 1'b0;
        m_fired = 1'b1;
      end else begin
        if (q_s.size() > 0 && q_s[0] == e) begin
          m_report = q_w.pop_front();
          void'(q_s.pop_front());
          m_last_show = e;
        end
        if (m_fin && q_s.size() == 0 && e >= m_last_show + 4) begin
          m_done = 1'b1;
          m_succ = m_fin_ok;
        end
        if (acc && a == ADDR_PUSH && !m_done) begin
          s = (e + 2 > m_last_sched + 5) ? e + 2 : m_last_sched + 5;
          q_w.push_back(d);
          q_s.push_back(s);
          m_last_sched = s;
        end
        if (acc && a == ADDR_FINISH && !m_fin) begin
          m_fin = 1'b1;
          m_fin_ok = d[0];
        end
      end
    end
    if (acc) m_last_acc = e;
    m_ready = m_done || pending(e) < 8;
  endtask
  task automatic tick;
    logic acc;
    logic [1:0] a;
    logic [31:0] d;
    acc = bus.valid && m_ready;
    a = bus.addr;
    d = bus.data;
    @(posedge refclk);
    e++;
    model_edge(acc, a, d);
    tick_acc = acc;
    @(negedge refclk);
    chk("report", sim_report, m_report);
    chk("done", 32'(sim_done), 32'(m_done));
    chk("success", 32'(sim_success), 32'(m_succ));
    chk("wdt_fired", 32'(wdt_fired), 32'(m_fired));
    chk("ready", 32'(bus.ready), 32'(m_ready));
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int i = 0;
    bus.valid = 1'b1;
    bus.addr = a;
    bus.data = d;
    do begin
      tick();
      i++;
    end while (!tick_acc && i < 100);
    if (!tick_acc) begin
      total++;
      fails++;
      $error("FAIL wr_timeout observed=not accepted expected=accepted within 100 cycles");
    end
    bus.valid = 1'b0;
  endtask
  task automatic idle(input int n);
    bus.valid = 1'b0;
    repeat (n) tick();
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.valid = 1'b0;
    @(posedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    model_reset();
    chk("rst_report", sim_report, 32'h0);
    chk("rst_done", 32'(sim_done), 32'h0);
    chk("rst_success", 32'(sim_success), 32'h0);
    chk("rst_wdt", 32'(wdt_fired), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h1);
  endtask
  initial begin
    logic [31:0] x;
    logic fb;
    int n;
    bus.valid = 1'b0;
    bus.addr = 2'd0;
    bus.data = '0;
    model_reset();
    do_reset();
    // single word: visible two edges after acceptance, held at least five cycles
    wr(ADDR_PUSH, 32'h0000_0001);
    tick();
    chk("lat_n1", sim_report, 32'h0);
    tick();
    chk("lat_n2", sim_report, 32'h1);
    idle(4);
    chk("hold5", sim_report, 32'h1);
    chk("hold5_done", 32'(sim_done), 32'h0);
    // back-to-back burst that fills the FIFO
    do_reset();
    for (int k = 1; k <= 10; k++) wr(ADDR_PUSH, 32'(k));
    chk("ready_full", 32'(bus.ready), 32'h0);
    wr(ADDR_PUSH, 32'd11);
    wr(ADDR_PUSH, 32'd12);
    idle(60);
    chk("burst_last", sim_report, 32'd12);
    // finish after queued words
    do_reset();
    x = $urandom;
    wr(ADDR_PUSH, x);
    wr(ADDR_PUSH, ~x);
    wr(ADDR_FINISH, 32'h1);
    idle(20);
    chk("fin_report", sim_report, ~x);
    chk("fin_success", 32'(sim_success), 32'h1);
    // first finish wins, later pushes are discarded
    do_reset();
    wr(ADDR_FINISH, 32'h0);
    wr(ADDR_FINISH, 32'h1);
    idle(3);
    wr(ADDR_PUSH, $urandom);
    wr(ADDR_PUSH, $urandom);
    idle(8);
    chk("late_report", sim_report, 32'h0);
    chk("late_success", 32'(sim_success), 32'h0);
    // watchdog expiry with no writes
    do_reset();
    idle(99);
    chk("wdt_pre", 32'(sim_done), 32'h0);
    idle(1);
    chk("wdt_report", sim_report, 32'hDEAD_0000);
    chk("wdt_flag", 32'(wdt_fired), 32'h1);
    idle(5);
    // kick in the expiry cycle wins, then the next window expires
    do_reset();
    idle(99);
    wr(ADDR_KICK, $urandom);
    chk("kick_nofire", 32'(wdt_fired), 32'h0);
    idle(99);
    chk("kick_pre2", 32'(sim_done), 32'h0);
    idle(1);
    chk("kick_fire2", 32'(wdt_fired), 32'h1);
    wr(ADDR_RSVD, $urandom);
    // async reset while holding a word with three queued
    do_reset();
    for (int k = 0; k < 4; k++) wr(ADDR_PUSH, $urandom | 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_report", sim_report, 32'h0);
    chk("arst_done", 32'(sim_done), 32'h0);
    chk("arst_wdt", 32'(wdt_fired), 32'h0);
    chk("arst_ready", 32'(bus.ready), 32'h1);
    @(negedge refclk);
    rst = 1'b0;
    model_reset();
    x = $urandom | 32'h1;
    wr(ADDR_PUSH, x);
    tick();
    chk("arst_n1", sim_report, 32'h0);
    tick();
    chk("arst_n2", sim_report, x);
    // random pushes with gaps, then a random verdict
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        wr(ADDR_PUSH, $urandom);
        idle($urandom_range(0, 6));
      end
      fb = 1'($urandom_range(0, 1));
      wr(ADDR_FINISH, {31'h0, fb});
      idle(80);
      chk("rand_done", 32'(sim_done), 32'h1);
      chk("rand_success", 32'(sim_success), 32'(fb));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
